// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter feeding a one-entry registered output stage
module wb_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int XLEN = 32,
  parameter int ID_W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_UNITS-1:0]      unit_done,
  input  logic [NUM_UNITS*ID_W-1:0] unit_id,
  input  logic [NUM_UNITS*XLEN-1:0] unit_rd,
  output logic [NUM_UNITS-1:0]      unit_ack,
  output logic                      wb_valid,
  output logic [ID_W-1:0]           wb_id,
  output logic [XLEN-1:0]           wb_data,
  input  logic                      wb_ready
);
  localparam int PW = $clog2(NUM_UNITS);
  logic [PW-1:0] r_ptr, w_g, w_idx, w_ptr_nxt;
  logic r_valid, w_adv, w_req, w_gnt;
  logic [ID_W-1:0] r_id;
  logic [XLEN-1:0] r_data;
  always_comb begin
    w_g = '0;
    w_idx = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      w_idx = PW'((int'(r_ptr) + i) % NUM_UNITS);
      w_g = unit_done[w_idx] ? w_idx : w_g;
    end
  end
  assign w_adv = ~r_valid | wb_ready;
  assign w_req = |unit_done;
  assign w_gnt = w_adv & w_req & ~rst;
  assign w_ptr_nxt = (w_g == PW'(NUM_UNITS - 1)) ? '0 : w_g + 1'b1;
  assign unit_ack = w_gnt ? ({{(NUM_UNITS-1){1'b0}}, 1'b1} << w_g) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ptr <= '0;
      r_id <= '0;
      r_data <= '0;
    end else if (w_adv) begin
      r_valid <= w_req;
      if (w_req) begin
        r_id <= unit_id[w_g*ID_W +: ID_W];
        r_data <= unit_rd[w_g*XLEN +: XLEN];
        r_ptr <= w_ptr_nxt;
      end
    end
  end
  assign wb_valid = r_valid;
  assign wb_id = r_id;
  assign wb_data = r_data;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized and directed checks of wb_arbiter against a behavioural model
module tb_wb_arbiter;
  localparam int N = 4;
  localparam int XLEN = 32;
  localparam int ID_W = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] unit_done = '1;
  logic [N*ID_W-1:0] unit_id = '0;
  logic [N*XLEN-1:0] unit_rd = '0;
  logic [N-1:0] unit_ack;
  logic wb_valid;
  logic [ID_W-1:0] wb_id;
  logic [XLEN-1:0] wb_data;
  logic wb_ready = 1'b1;
  int checks = 0;
  int failures = 0;
  int m_ptr = 0;
  bit m_valid = 0;
  logic [ID_W-1:0] m_id = '0;
  logic [XLEN-1:0] m_data = '0;
  int last_g = -1;
  int acks [N];
  int order [$];

  wb_arbiter #(.NUM_UNITS(N), .XLEN(XLEN), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .unit_done(unit_done), .unit_id(unit_id), .unit_rd(unit_rd),
    .unit_ack(unit_ack), .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .wb_ready(wb_ready)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_unit(int k, logic [ID_W-1:0] id, logic [XLEN-1:0] rd);
    unit_done[k] = 1'b1;
    unit_id[k*ID_W +: ID_W] = id;
    unit_rd[k*XLEN +: XLEN] = rd;
  endtask

  // entered at posedge+1 with inputs driven; returns at next posedge+1 with model advanced
  task automatic cycle();
    int g;
    bit adv;
    #4;
    adv = !m_valid || wb_ready;
    g = -1;
    if (!rst && adv)
      for (int k = 0; k < N; k++)
        if (g < 0 && unit_done[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    check("ack", unit_ack, g < 0 ? 0 : (1 << g));
    check("wb_valid", wb_valid, m_valid);
    if (m_valid) begin
      check("wb_id", wb_id, m_id);
      check("wb_data", wb_data, m_data);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_ptr = 0; m_id = '0; m_data = '0;
    end else if (adv) begin
      m_valid = (g >= 0);
      last_g = g;
      if (g >= 0) begin
        m_id = unit_id[g*ID_W +: ID_W];
        m_data = unit_rd[g*XLEN +: XLEN];
        m_ptr = (g + 1) % N;
        unit_done[g] = 1'b0;
        acks[g]++;
        order.push_back(g);
      end
    end else last_g = -1;
  endtask

  initial begin
    for (int k = 0; k < N; k++) set_unit(k, ID_W'(k + 1), XLEN'(32'h1000 * (k + 1)));
    @(posedge clk);
    @(posedge clk);
    #1;
    repeat (2) cycle();
    rst = 1'b0;
    check("rst_id", wb_id, 0);
    check("rst_data", wb_data, 0);
    cycle();
    check("first_grant", last_g, 0);
    unit_done = '0;
    repeat (3) cycle();
    // single source
    set_unit(2, 3'd5, 32'hDEADBEEF);
    cycle();
    check("single_g", last_g, 2);
    check("single_ptr", m_ptr, 3);
    #4;
    check("single_valid", wb_valid, 1);
    check("single_id", wb_id, 5);
    check("single_data", wb_data, 32'hDEADBEEF);
    #1;
    @(posedge clk); #1;
    m_valid = 0;
    // wrap with ptr=3
    set_unit(0, 3'd1, 32'hA0A0A0A0);
    set_unit(3, 3'd3, 32'hB3B3B3B3);
    cycle();
    check("wrap_g3", last_g, 3);
    check("wrap_ptr0", m_ptr, 0);
    cycle();
    check("wrap_g0", last_g, 0);
    check("wrap_ptr1", m_ptr, 1);
    cycle();
    // all requesting, 8 grants, starting from ptr=0
    while (m_ptr != 0) begin
      set_unit(m_ptr, 3'd0, 32'h0);
      cycle();
    end
    for (int k = 0; k < N; k++) acks[k] = 0;
    order.delete();
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < N; k++) if (!unit_done[k]) set_unit(k, ID_W'($urandom), $urandom);
      cycle();
    end
    for (int k = 0; k < N; k++) check("fair_cnt", acks[k], 2);
    check("fair_len", order.size(), 8);
    for (int c = 0; c < order.size(); c++) check("fair_order", order[c], c % N);
    unit_done = '0;
    cycle();
    cycle();
    // backpressure: get a result into the stage, then stall with units 1 and 3
    set_unit(0, 3'd6, 32'h600D600D);
    cycle();
    wb_ready = 1'b0;
    set_unit(1, 3'd1, 32'h11111111);
    set_unit(3, 3'd3, 32'h33333333);
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("stall_noack", last_g, -1);
    end
    wb_ready = 1'b1;
    cycle();
    check("release_g", last_g, 1);
    cycle();
    check("release_g2", last_g, 3);
    // reset mid-stall
    set_unit(2, 3'd2, 32'h22222222);
    cycle();
    wb_ready = 1'b0;
    set_unit(0, 3'd7, 32'h77777777);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rststall_ptr", m_ptr, 0);
    wb_ready = 1'b1;
    cycle();
    check("rststall_g", last_g, 0);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++)
        if (!unit_done[k] && $urandom_range(0, 1)) set_unit(k, ID_W'($urandom), $urandom);
      wb_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
